// File: rtl/sub_div_ctrl.sv
// Repeated-subtraction divide sequencer driving an external subtractor SFR.
// Quotient counts subtractions; remainder is the SFR value left at the end.
module sub_div_ctrl #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [SIZE-1:0] dividend,
  input  logic [SIZE-1:0] divisor,
  input  logic [SIZE-1:0] sfr_q,
  output logic            sfr_ld,
  output logic            sfr_sub,
  output logic [SIZE-1:0] sfr_d,
  output logic [SIZE-1:0] sfr_s,
  output logic            busy,
  output logic            done,
  output logic            div_by_zero,
  output logic [SIZE-1:0] quotient,
  output logic [SIZE-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CHECK,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [SIZE-1:0] dvd_q, dvd_d;
  logic [SIZE-1:0] dvs_q, dvs_d;
  logic [SIZE-1:0] quo_q, quo_d;
  logic [SIZE-1:0] rem_q, rem_d;
  logic            dbz_q, dbz_d;
  logic            sub_q, sub_d;

  // sub_q is computed one cycle ahead from the value the SFR will hold,
  // so the strobe is registered yet lines up with the current sfr_q.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    sub_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dvd_d = dividend;
          dvs_d = divisor;
          quo_d = '0;
          rem_d = '0;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            state_d = DONE;
            dbz_d   = 1'b1;
            quo_d   = '1;
            rem_d   = dividend;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        sub_d   = (dvd_q >= dvs_q);
        state_d = CHECK;
      end
      CHECK: begin
        if (sub_q) begin
          quo_d = quo_q + SIZE'(1);
          sub_d = ((sfr_q - dvs_q) >= dvs_q);
        end else begin
          rem_d   = sfr_q;
          state_d = DONE;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      sub_q   <= sub_d;
    end
  end

  assign sfr_ld      = (state_q == LOAD);
  assign sfr_sub     = sub_q;
  assign sfr_d       = dvd_q;
  assign sfr_s       = dvs_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;

endmodule

// File: tb/tb_sub_div_ctrl.sv
// Bench for sub_div_ctrl: 32-bit and 8-bit instances, each with an SFR model,
// checked against integer division and the documented cycle latency.
module tb_sub_div_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        use8 = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;

  logic        ld32, sub32, busy32, done32, dbz32;
  logic [31:0] d32, s32, q32, r32;
  logic [31:0] sfrq32 = '0;

  logic        ld8, sub8, busy8, done8, dbz8;
  logic [7:0]  d8, s8, q8, r8;
  logic [7:0]  sfrq8 = '0;

  logic        start32, start8;
  assign start32 = start & ~use8;
  assign start8  = start & use8;

  always #5 clk = ~clk;

  sub_div_ctrl #(.SIZE(32)) u32 (
    .clk(clk), .rst(rst), .start(start32),
    .dividend(dividend), .divisor(divisor), .sfr_q(sfrq32),
    .sfr_ld(ld32), .sfr_sub(sub32), .sfr_d(d32), .sfr_s(s32),
    .busy(busy32), .done(done32), .div_by_zero(dbz32),
    .quotient(q32), .remainder(r32)
  );

  sub_div_ctrl #(.SIZE(8)) u8 (
    .clk(clk), .rst(rst), .start(start8),
    .dividend(dividend[7:0]), .divisor(divisor[7:0]), .sfr_q(sfrq8),
    .sfr_ld(ld8), .sfr_sub(sub8), .sfr_d(d8), .sfr_s(s8),
    .busy(busy8), .done(done8), .div_by_zero(dbz8),
    .quotient(q8), .remainder(r8)
  );

  // Subtractor SFR models, no reset.
  always_ff @(posedge clk) begin
    if (ld32) sfrq32 <= d32;
    else if (sub32) sfrq32 <= sfrq32 - s32;
  end

  always_ff @(posedge clk) begin
    if (ld8) sfrq8 <= d8;
    else if (sub8) sfrq8 <= sfrq8 - s8;
  end

  logic        m_ld, m_sub, m_busy, m_done, m_dbz;
  logic [31:0] m_q, m_r;
  assign m_ld   = use8 ? ld8 : ld32;
  assign m_sub  = use8 ? sub8 : sub32;
  assign m_busy = use8 ? busy8 : busy32;
  assign m_done = use8 ? done8 : done32;
  assign m_dbz  = use8 ? dbz8 : dbz32;
  assign m_q    = use8 ? {24'b0, q8} : q32;
  assign m_r    = use8 ? {24'b0, r8} : r32;

  int n_cmp = 0;
  int n_fail = 0;
  int subs, lds, cyc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a start at the next edge; returns in cycle 1.
  task automatic go(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    cyc  = 1;
    subs = 0;
    lds  = 0;
    while (!m_done && cyc < limit) begin
      subs += int'(m_sub);
      lds  += int'(m_ld);
      tick();
      cyc++;
    end
  endtask

  task automatic check_run(input string tag, input logic [31:0] a,
                           input logic [31:0] b);
    logic [31:0] eq, er, ones;
    int          elat;
    ones = use8 ? 32'hFF : 32'hFFFF_FFFF;
    if (b == 0) begin
      eq = ones;
      er = a;
      elat = 1;
    end else begin
      eq = a / b;
      er = a % b;
      elat = int'(eq) + 3;
    end
    go(a, b);
    dividend = $urandom;
    divisor  = $urandom;
    chk({tag, " busy1"}, m_busy, 1'b1);
    wait_done(elat + 10);
    chk({tag, " done"}, m_done, 1'b1);
    chk({tag, " latency"}, cyc, elat);
    chk({tag, " quotient"}, m_q, eq);
    chk({tag, " remainder"}, m_r, er);
    chk({tag, " dbz"}, m_dbz, b == 0);
    chk({tag, " subs"}, subs, (b == 0) ? 0 : int'(eq));
    chk({tag, " loads"}, lds, (b == 0) ? 0 : 1);
    tick();
    chk({tag, " idle_done"}, m_done, 1'b0);
    chk({tag, " idle_busy"}, m_busy, 1'b0);
    chk({tag, " held_q"}, m_q, eq);
  endtask

  task automatic chk_zero32(input string tag);
    chk({tag, " busy"}, busy32, 1'b0);
    chk({tag, " done"}, done32, 1'b0);
    chk({tag, " ld"}, ld32, 1'b0);
    chk({tag, " sub"}, sub32, 1'b0);
    chk({tag, " dbz"}, dbz32, 1'b0);
    chk({tag, " q"}, q32, 32'd0);
    chk({tag, " r"}, r32, 32'd0);
    chk({tag, " d"}, d32, 32'd0);
    chk({tag, " s"}, s32, 32'd0);
  endtask

  initial begin
    logic        seen;
    logic [31:0] a, b;

    repeat (3) tick();
    chk_zero32("reset");
    @(negedge clk);
    rst = 1'b0;

    check_run("100/7", 100, 7);
    check_run("5/9", 5, 9);
    check_run("42/0", 42, 0);

    use8 = 1'b1;
    check_run("w8 255/1", 255, 1);
    check_run("w8 9/3", 9, 3);
    chk("w8 sfr_q end", {24'b0, sfrq8}, 32'd0);
    use8 = 1'b0;

    // Start pulsed mid-run is ignored.
    go(100, 7);
    cyc = 1;
    while (!done32 && cyc < 40) begin
      if (cyc == 5) begin
        @(negedge clk);
        start    = 1'b1;
        dividend = 50;
        divisor  = 5;
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    chk("ign latency", cyc, 17);
    chk("ign quotient", q32, 14);
    chk("ign remainder", r32, 2);
    chk("ign sfr_d", d32, 100);
    tick();
    check_run("after 50/5", 50, 5);

    // Reset in the middle of a run.
    go(100, 7);
    cyc = 1;
    while (cyc < 6) begin
      tick();
      cyc++;
    end
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk_zero32("midrst");
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= done32;
    end
    chk("midrst nodone", seen, 1'b0);
    check_run("fresh 100/7", 100, 7);

    for (int i = 0; i < 12; i++) begin
      a = $urandom_range(0, 1000);
      b = (i % 5 == 0) ? 0 : $urandom_range(1, 60);
      check_run("rand32", a, b);
    end
    use8 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, 255);
      b = (i == 3) ? 0 : $urandom_range(1, 255);
      check_run("rand8", a, b);
    end
    use8 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
